lane_frame_loader: RTL and testbench

Sequential writer that feeds the 4-lane shift/multiplex datapath. It accepts a stream of WIDTH-bit words over a valid/ready handshake and shifts each word into a 4-lane register bank from the end selected by a per-frame direction bit. It then presents the completed frame (A0..A3 plus the direction) to the shifter stage over a second valid/ready handshake. It is the producer for the combinational lane shifter: it builds the parallel lane words that the shifter consumes.

---
 rtl/lane_frame_loader.sv | 116 +++++++++++
 tb/tb_lane_frame_loader.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/lane_frame_loader.sv
// Loads four WIDTH-bit words into lanes A0..A3, shifting from the end picked
// by the per-frame direction bit, then offers the frame over valid/ready.
// Ports: clk, rst_n (async, active low), flush (sync clear);
//        in_valid/in_ready/in_data/in_dir: word input handshake;
//        out_valid/out_ready, A0..A3, out_dir: frame output handshake;
//        frame_cnt: frames delivered, wrapping at 8 bits.
module lane_frame_loader #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_dir,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] A0,
    output logic [WIDTH-1:0] A1,
    output logic [WIDTH-1:0] A2,
    output logic [WIDTH-1:0] A3,
    output logic             out_dir,
    output logic [7:0]       frame_cnt
);

    typedef enum logic {FILL, FULL} state_t;

    state_t           state, state_nxt;
    logic [1:0]       cnt, cnt_nxt;
    logic [WIDTH-1:0] a0_nxt, a1_nxt, a2_nxt, a3_nxt;
    logic             dir_nxt;
    logic [7:0]       frame_nxt;
    logic             accept;
    logic             frame_done;
    logic             dir_use;

    assign out_valid  = (state == FULL);
    assign in_ready   = rst_n && ((state == FILL) || out_ready);
    assign accept     = in_valid && in_ready;
    assign frame_done = out_valid && out_ready;
    // Word 0 shifts with its own in_dir; later words follow the latched one.
    assign dir_use    = (cnt == 2'd0) ? in_dir : out_dir;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            cnt       <= 2'd0;
            A0        <= '0;
            A1        <= '0;
            A2        <= '0;
            A3        <= '0;
            out_dir   <= 1'b0;
            frame_cnt <= 8'd0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            A0        <= a0_nxt;
            A1        <= a1_nxt;
            A2        <= a2_nxt;
            A3        <= a3_nxt;
            out_dir   <= dir_nxt;
            frame_cnt <= frame_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        a0_nxt    = A0;
        a1_nxt    = A1;
        a2_nxt    = A2;
        a3_nxt    = A3;
        dir_nxt   = out_dir;
        frame_nxt = frame_cnt;

        // A frame handed off in a flush cycle still counts.
        if (frame_done)
            frame_nxt = frame_cnt + 8'd1;

        if (flush) begin
            state_nxt = FILL;
            cnt_nxt   = 2'd0;
            a0_nxt    = '0;
            a1_nxt    = '0;
            a2_nxt    = '0;
            a3_nxt    = '0;
            dir_nxt   = 1'b0;
        end else begin
            if (frame_done)
                state_nxt = FILL;
            if (accept) begin
                if (dir_use) begin
                    a0_nxt = A1;
                    a1_nxt = A2;
                    a2_nxt = A3;
                    a3_nxt = in_data;
                end else begin
                    a3_nxt = A2;
                    a2_nxt = A1;
                    a1_nxt = A0;
                    a0_nxt = in_data;
                end
                if (cnt == 2'd0)
                    dir_nxt = in_dir;
                if (cnt == 2'd3) begin
                    state_nxt = FULL;
                    cnt_nxt   = 2'd0;
                end else begin
                    cnt_nxt = cnt + 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lane_frame_loader.sv
// Directed bench for lane_frame_loader: fill order, direction latching,
// back-pressure, continuous streaming with wrap, flush and async reset.
module tb_lane_frame_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       in_dir;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] A0, A1, A2, A3;
    logic       out_dir;
    logic [7:0] frame_cnt;

    int pass_cnt = 0;
    int total    = 0;

    lane_frame_loader #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_dir(in_dir),
        .out_valid(out_valid), .out_ready(out_ready),
        .A0(A0), .A1(A1), .A2(A2), .A3(A3),
        .out_dir(out_dir), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic lanes(input string tag, input logic [3:0] e0,
                         input logic [3:0] e1, input logic [3:0] e2,
                         input logic [3:0] e3);
        chk({tag, "_a0"}, 32'(A0), 32'(e0));
        chk({tag, "_a1"}, 32'(A1), 32'(e1));
        chk({tag, "_a2"}, 32'(A2), 32'(e2));
        chk({tag, "_a3"}, 32'(A3), 32'(e3));
    endtask

    task automatic push(input logic [3:0] d, input logic dir);
        in_valid = 1'b1;
        in_data  = d;
        in_dir   = dir;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] w [4];
        logic       fdir;
        logic [7:0] exp_fc;

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_dir    = 1'b0;
        out_ready = 1'b1;

        // Reset state
        #12;
        lanes("rst", 4'h0, 4'h0, 4'h0, 4'h0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_fc", 32'(frame_cnt), 32'd0);
        chk("rst_dir", 32'(out_dir), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rdy_after_rst", 32'(in_ready), 32'd1);

        // dir=0 frame 1,2,3,4
        push(4'd1, 1'b0);
        chk("t1_valid_w0", 32'(out_valid), 32'd0);
        push(4'd2, 1'b0);
        push(4'd3, 1'b0);
        push(4'd4, 1'b0);
        chk("t1_valid", 32'(out_valid), 32'd1);
        lanes("t1", 4'd4, 4'd3, 4'd2, 4'd1);
        chk("t1_dir", 32'(out_dir), 32'd0);
        chk("t1_fc_pre", 32'(frame_cnt), 32'd0);
        idle();
        chk("t1_fc", 32'(frame_cnt), 32'd1);
        chk("t1_valid_off", 32'(out_valid), 32'd0);

        // dir=1 with in_dir toggled on later words
        push(4'hA, 1'b1);
        push(4'hB, 1'b0);
        push(4'hC, 1'b1);
        push(4'hD, 1'b0);
        chk("t2_valid", 32'(out_valid), 32'd1);
        lanes("t2", 4'hA, 4'hB, 4'hC, 4'hD);
        chk("t2_dir", 32'(out_dir), 32'd1);

        // Back-pressure for 5 cycles
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 4'd5;
        in_dir    = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
            chk("bp_valid", 32'(out_valid), 32'd1);
            lanes("bp", 4'hA, 4'hB, 4'hC, 4'hD);
            chk("bp_dir", 32'(out_dir), 32'd1);
        end
        chk("bp_fc", 32'(frame_cnt), 32'd1);
        out_ready = 1'b1;
        #1;
        chk("bp_rel_ready", 32'(in_ready), 32'd1);
        push(4'd5, 1'b0);
        chk("bp_rel_fc", 32'(frame_cnt), 32'd2);
        chk("bp_rel_valid", 32'(out_valid), 32'd0);
        chk("bp_rel_dir", 32'(out_dir), 32'd0);
        lanes("bp_rel", 4'd5, 4'hA, 4'hB, 4'hC);
        push(4'd6, 1'b1);
        push(4'd7, 1'b1);
        push(4'd8, 1'b1);
        chk("t3_valid", 32'(out_valid), 32'd1);
        lanes("t3", 4'd8, 4'd7, 4'd6, 4'd5);
        chk("t3_dir", 32'(out_dir), 32'd0);
        idle();
        chk("t3_fc", 32'(frame_cnt), 32'd3);

        // 256 back-to-back frames, frame_cnt passes through 0
        in_valid = 1'b1;
        for (int f = 0; f < 256; f++) begin
            fdir = f[0];
            for (int k = 0; k < 4; k++) begin
                w[k]    = 4'(f * 4 + k);
                in_data = w[k];
                in_dir  = (k == 0) ? fdir : ~fdir;
                @(posedge clk);
                #1;
                if (k == 3) begin
                    chk("st_valid", 32'(out_valid), 32'd1);
                    chk("st_dir", 32'(out_dir), 32'(fdir));
                    if (fdir)
                        lanes("st1", w[0], w[1], w[2], w[3]);
                    else
                        lanes("st0", w[3], w[2], w[1], w[0]);
                end else begin
                    chk("st_novalid", 32'(out_valid), 32'd0);
                end
                if (k == 0) begin
                    exp_fc = 8'(3 + f);
                    chk("st_fc", 32'(frame_cnt), 32'(exp_fc));
                end
            end
        end
        idle();
        chk("st_fc_end", 32'(frame_cnt), 32'd3);

        // Flush after two words
        push(4'd9, 1'b1);
        push(4'd10, 1'b0);
        flush   = 1'b1;
        in_data = 4'd11;
        push(4'd11, 1'b1);
        flush = 1'b0;
        lanes("fl", 4'd0, 4'd0, 4'd0, 4'd0);
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk("fl_dir", 32'(out_dir), 32'd0);
        chk("fl_fc", 32'(frame_cnt), 32'd3);
        push(4'd1, 1'b1);
        push(4'd2, 1'b0);
        push(4'd3, 1'b0);
        push(4'd4, 1'b0);
        chk("fl_frame_valid", 32'(out_valid), 32'd1);
        lanes("fl_frame", 4'd1, 4'd2, 4'd3, 4'd4);
        chk("fl_frame_dir", 32'(out_dir), 32'd1);
        // Flush during a frame handshake: frame still counted
        flush = 1'b1;
        idle();
        flush = 1'b0;
        chk("fl_hs_fc", 32'(frame_cnt), 32'd4);
        chk("fl_hs_valid", 32'(out_valid), 32'd0);
        lanes("fl_hs", 4'd0, 4'd0, 4'd0, 4'd0);

        // Asynchronous reset mid-frame
        push(4'd5, 1'b1);
        push(4'd6, 1'b1);
        in_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        lanes("ar", 4'd0, 4'd0, 4'd0, 4'd0);
        chk("ar_ready", 32'(in_ready), 32'd0);
        chk("ar_fc", 32'(frame_cnt), 32'd0);
        chk("ar_dir", 32'(out_dir), 32'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        push(4'd1, 1'b0);
        push(4'd2, 1'b1);
        push(4'd3, 1'b1);
        push(4'd4, 1'b1);
        chk("ar_frame_valid", 32'(out_valid), 32'd1);
        lanes("ar_frame", 4'd4, 4'd3, 4'd2, 4'd1);
        chk("ar_frame_dir", 32'(out_dir), 32'd0);
        idle();
        chk("ar_frame_fc", 32'(frame_cnt), 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
